// File: rtl/sat_counter_table.sv
// Table of saturating prediction counters with NUM_RD registered read ports,
// a 2-stage read-modify-write update port and a self-initialising reset sweep.
module sat_counter_table #(
  parameter int NUM_ENTRIES = 512,
  parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  parameter int CTR_WIDTH   = 2,
  parameter int NUM_RD      = 2,
  parameter logic [CTR_WIDTH-1:0] INIT_VALUE = CTR_WIDTH'(1) << (CTR_WIDTH - 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_busy,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*CTR_WIDTH-1:0]    rd_data,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [ADDR_WIDTH-1:0]          upd_addr,
  input  logic                           upd_taken,
  input  logic                           upd_write,
  input  logic [CTR_WIDTH-1:0]           upd_wdata
);

  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_MIN  = '0;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic [CTR_WIDTH-1:0]  mem [NUM_ENTRIES];

  // Update stage register: captured on accept, written back one edge later.
  logic                  s2_valid_q;
  logic [ADDR_WIDTH-1:0] s2_addr_q;
  logic                  s2_taken_q;
  logic                  s2_write_q;
  logic [CTR_WIDTH-1:0]  s2_wdata_q;
  logic [CTR_WIDTH-1:0]  s2_old_q;
  logic [CTR_WIDTH-1:0]  s2_new;
  logic                  upd_accept;
  logic                  upd_fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    init_busy = 1'b0;
    upd_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        idx_d     = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_READY;
          idx_d   = '0;
        end
      end
      ST_READY: begin
        upd_ready = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  assign upd_accept = upd_valid && upd_ready;
  assign upd_fwd    = s2_valid_q && (s2_addr_q == upd_addr);

  always_comb begin
    s2_new = s2_old_q;
    if (s2_write_q) begin
      s2_new = s2_wdata_q;
    end else if (s2_taken_q) begin
      if (s2_old_q != CTR_MAX) s2_new = s2_old_q + CTR_WIDTH'(1);
    end else begin
      if (s2_old_q != CTR_MIN) s2_new = s2_old_q - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= upd_accept;
    end
  end

  // Back-to-back updates to one entry take the in-flight result, not the stale word.
  always_ff @(posedge clk) begin
    if (upd_accept) begin
      s2_addr_q  <= upd_addr;
      s2_taken_q <= upd_taken;
      s2_write_q <= upd_write;
      s2_wdata_q <= upd_wdata;
      s2_old_q   <= upd_fwd ? s2_new : mem[upd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[idx_q] <= INIT_VALUE;
      end else if (s2_valid_q) begin
        mem[s2_addr_q] <= s2_new;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [CTR_WIDTH-1:0]  rd_data_q;

    assign port_addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    // Write-first: a read hitting the entry being written this edge sees the new value.
    always_ff @(posedge clk) begin
      if (rst || (state_q == ST_INIT)) begin
        rd_data_q <= '0;
      end else if (rd_en[gi]) begin
        rd_data_q <= (s2_valid_q && (s2_addr_q == port_addr)) ? s2_new : mem[port_addr];
      end
    end

    assign rd_data[gi*CTR_WIDTH +: CTR_WIDTH] = rd_data_q;
  end

endmodule

// File: tb/tb_sat_counter_table.sv
// Directed table-driven bench for sat_counter_table (512 x 2-bit, 2 read ports).
module tb_sat_counter_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_busy;
  logic [1:0]  rd_en;
  logic [17:0] rd_addr;
  logic [3:0]  rd_data;
  logic        upd_valid;
  logic        upd_ready;
  logic [8:0]  upd_addr;
  logic        upd_taken;
  logic        upd_write;
  logic [1:0]  upd_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  sat_counter_table dut (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_addr  (upd_addr),
    .upd_taken (upd_taken),
    .upd_write (upd_write),
    .upd_wdata (upd_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       uv;
    logic [8:0] ua;
    logic       ut;
    logic       uw;
    logic [1:0] ud;
    logic [1:0] ren;
    logic [8:0] ra0;
    logic [8:0] ra1;
    logic [1:0] chk;
    logic [1:0] e0;
    logic [1:0] e1;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic add(input logic uv, input int ua, input logic ut, input logic uw, input int ud,
                     input logic [1:0] ren, input int ra0, input int ra1,
                     input logic [1:0] chk, input int e0, input int e1);
    vec_t v;
    v.uv = uv; v.ua = 9'(ua); v.ut = ut; v.uw = uw; v.ud = 2'(ud);
    v.ren = ren; v.ra0 = 9'(ra0); v.ra1 = 9'(ra1);
    v.chk = chk; v.e0 = 2'(e0); v.e1 = 2'(e1);
    vecs.push_back(v);
  endtask

  task automatic read0(input string name, input int a, input int exp);
    rd_en        = 2'b01;
    rd_addr[8:0] = 9'(a);
    tick();
    rd_en = 2'b00;
    check(name, {30'd0, rd_data[1:0]}, exp);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; rd_en = '0; rd_addr = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0; upd_write = 1'b0; upd_wdata = '0;

    // All counters start at 2; each record is one cycle, checks target that cycle's reads.
    add(0,   0, 0, 0, 0, 2'b11,   0, 255, 2'b11, 2, 2);
    add(0,   0, 0, 0, 0, 2'b01, 511,   0, 2'b01, 2, 0);
    add(1,   5, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b01,   5,   0, 2'b01, 3, 0);
    add(1,   5, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b01,   5,   0, 2'b01, 3, 0);
    add(1,   5, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b10,   0,   5, 2'b10, 0, 3);
    add(0,   0, 0, 0, 0, 2'b11,   5,   5, 2'b11, 3, 3);
    add(0,   0, 0, 0, 0, 2'b00,   9,   9, 2'b11, 3, 3);
    add(1,   9, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(1,   9, 0, 0, 0, 2'b10,   0,   9, 2'b10, 0, 1);
    add(1,   9, 0, 0, 0, 2'b01,   9,   0, 2'b01, 0, 0);
    add(1,   9, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b11,   9,   9, 2'b11, 0, 0);
    add(0,   0, 0, 0, 0, 2'b01,   9,   0, 2'b01, 0, 0);
    add(1,   7, 1, 0, 0, 2'b10,   0,   7, 2'b10, 0, 2);
    add(0,   0, 0, 0, 0, 2'b01,   7,   0, 2'b01, 3, 0);
    add(1, 100, 1, 1, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(1, 100, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b01, 100,   0, 2'b01, 1, 0);
    add(1, 200, 0, 1, 3, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b10,   0, 200, 2'b10, 0, 3);
    add(1, 300, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(1, 300, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(1, 300, 1, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b00,   0,   0, 2'b00, 0, 0);
    add(0,   0, 0, 0, 0, 2'b01, 300,   0, 2'b01, 3, 0);

    // Reset for two cycles, then the full sweep with reads enabled throughout.
    tick();
    tick();
    check("rst_init_busy", {31'd0, init_busy}, 1);
    check("rst_upd_ready", {31'd0, upd_ready}, 0);
    check("rst_rd_data", {28'd0, rd_data}, 0);
    rst     = 1'b0;
    rd_en   = 2'b11;
    rd_addr = {9'd3, 9'd0};
    cnt = 0;
    while (init_busy && cnt < 600) begin
      tick();
      cnt++;
    end
    rd_en = 2'b00;
    check("sweep_cycles", cnt, 512);
    check("sweep_rd_zero", {28'd0, rd_data}, 0);
    check("ready_after_sweep", {31'd0, upd_ready}, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      upd_valid = vecs[i].uv;
      upd_addr  = vecs[i].ua;
      upd_taken = vecs[i].ut;
      upd_write = vecs[i].uw;
      upd_wdata = vecs[i].ud;
      rd_en     = vecs[i].ren;
      rd_addr   = {vecs[i].ra1, vecs[i].ra0};
      tick();
      if (vecs[i].chk[0]) check($sformatf("vec%0d_rd0", i), {30'd0, rd_data[1:0]}, {30'd0, vecs[i].e0});
      if (vecs[i].chk[1]) check($sformatf("vec%0d_rd1", i), {30'd0, rd_data[3:2]}, {30'd0, vecs[i].e1});
    end
    upd_valid = 1'b0; upd_write = 1'b0; rd_en = 2'b00;

    // Reset again, abort the sweep at idx 300, then try an update during the new sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (300) tick();
    rst = 1'b1;
    tick();
    check("midrst_init_busy", {31'd0, init_busy}, 1);
    rst = 1'b0;
    cnt = 0;
    while (init_busy && cnt < 600) begin
      if (cnt == 9) begin
        upd_valid = 1'b1; upd_addr = 9'd3; upd_write = 1'b1; upd_wdata = 2'd0;
      end else begin
        upd_valid = 1'b0; upd_write = 1'b0;
      end
      tick();
      cnt++;
    end
    upd_valid = 1'b0; upd_write = 1'b0;
    check("midrst_sweep_cycles", cnt, 512);
    read0("midrst_dropped_addr3", 3, 2);
    read0("midrst_addr5", 5, 2);
    read0("midrst_addr511", 511, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
